// File: rtl/mmio_hub_if.sv
// rtl/mmio_hub_if.sv - processor data-port bus between the CPU/RAM side and mmio_hub
interface mmio_hub_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic                  wren;
    logic [31:0]           data_out;
    logic                  ram_wren;
    logic [31:0]           ram_q;

    // ram_q originates on the system side (external RAM), so it travels with the master.
    modport master (
        output address, data_in, wren, ram_q,
        input  data_out, ram_wren
    );

    modport slave (
        input  address, data_in, wren, ram_q,
        output data_out, ram_wren
    );
endinterface

// File: rtl/mmio_hub.sv
// rtl/mmio_hub.sv - per-player controller/rumble/sprite I/O hub with RAM pass-through
module mmio_hub #(
    parameter int                    NUM_PLAYERS = 2,
    parameter int                    CTRL_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 13,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 13'h1F00,
    parameter int                    DB_CYCLES   = 50000
) (
    input  logic                              clock,
    input  logic                              reset_btn,
    mmio_hub_if.slave                         bus,
    input  logic [NUM_PLAYERS*CTRL_WIDTH-1:0] gpio_in,
    output logic [NUM_PLAYERS-1:0]            gpio_out,
    input  logic                              vga_frame_sync,
    output logic [NUM_PLAYERS*128-1:0]        player_vga
);
    localparam int                    NP      = NUM_PLAYERS;
    localparam int                    CW      = CTRL_WIDTH;
    localparam int                    DBW     = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0]        DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] FC_OFF  = ADDR_WIDTH'(8 * NUM_PLAYERS);

    logic [NP*CW-1:0]          gpio_s1_q, gpio_s2_q, gpio_s3_q;
    logic                      vga_s1_q, vga_s2_q, vga_s3_q;
    logic [NP-1:0][CW-1:0]     deb_q, deb_d;
    logic [NP-1:0][CW-1:0]     edge_q, edge_d;
    logic [NP-1:0][DBW-1:0]    cnt_q, cnt_d;
    logic [NP-1:0][15:0]       timer_q, timer_d;
    logic [NP-1:0][127:0]      shadow_q, shadow_d;
    logic [NP-1:0][127:0]      vga_q, vga_d;
    logic [NP-1:0]             pending_q, pending_d;
    logic [31:0]               frame_cnt_q, frame_cnt_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      io_sel_q, io_sel_d;

    logic                      io_space;
    logic [ADDR_WIDTH-1:0]     offset;
    logic                      commit;
    logic                      rd;
    logic                      hit;
    logic [CW-1:0]             synced, prev_s, rise;

    assign io_space = (bus.address >= IO_BASE);
    assign offset   = bus.address - IO_BASE;
    assign rd       = ~bus.wren;
    assign commit   = vga_s2_q & ~vga_s3_q;
    assign io_sel_d = io_space;

    always_comb begin
        deb_d       = deb_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        timer_d     = timer_q;
        shadow_d    = shadow_q;
        vga_d       = vga_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        rdata_d     = '0;
        hit         = 1'b0;
        synced      = '0;
        prev_s      = '0;
        rise        = '0;

        if (commit) frame_cnt_d = frame_cnt_q + 32'd1;
        if (io_space && offset == FC_OFF) rdata_d = frame_cnt_q;

        for (int p = 0; p < NP; p++) begin
            hit    = io_space && (offset[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(p));
            synced = gpio_s2_q[p*CW +: CW];
            prev_s = gpio_s3_q[p*CW +: CW];

            // Only a vector that has held still for the full window may replace debounced.
            if (synced != prev_s) begin
                cnt_d[p] = '0;
            end else begin
                if (cnt_q[p] != DB_LAST) cnt_d[p] = cnt_q[p] + DBW'(1);
                if (cnt_q[p] == DB_LAST && synced != deb_q[p]) deb_d[p] = synced;
            end

            rise      = deb_d[p] & ~deb_q[p];
            edge_d[p] = ((hit && rd && offset[2:0] == 3'd5) ? '0 : edge_q[p]) | rise;

            if (timer_q[p] != 16'd0) timer_d[p] = timer_q[p] - 16'd1;

            if (commit) begin
                vga_d[p]     = shadow_q[p];
                pending_d[p] = 1'b0;
            end

            // Writes come after the commit so a colliding shadow write keeps pending set.
            if (hit && bus.wren) begin
                if (offset[2] == 1'b0) begin
                    shadow_d[p][{offset[1:0], 5'b0} +: 32] = bus.data_in;
                    pending_d[p] = 1'b1;
                end else if (offset[1:0] == 2'd2) begin
                    timer_d[p] = bus.data_in[15:0];
                end
            end

            if (hit) begin
                case (offset[2:0])
                    3'd4:    rdata_d = 32'(deb_q[p]);
                    3'd5:    rdata_d = 32'(edge_q[p]);
                    3'd6:    rdata_d = 32'(timer_q[p]);
                    3'd7:    rdata_d = {31'b0, pending_q[p]};
                    default: rdata_d = shadow_q[p][{offset[1:0], 5'b0} +: 32];
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            gpio_s1_q   <= '0;
            gpio_s2_q   <= '0;
            gpio_s3_q   <= '0;
            vga_s1_q    <= 1'b0;
            vga_s2_q    <= 1'b0;
            vga_s3_q    <= 1'b0;
            deb_q       <= '0;
            edge_q      <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            shadow_q    <= '0;
            vga_q       <= '0;
            pending_q   <= '0;
            frame_cnt_q <= '0;
            rdata_q     <= '0;
            // Select the zeroed I/O read register so data_out is 0 through reset.
            io_sel_q    <= 1'b1;
        end else begin
            gpio_s1_q   <= gpio_in;
            gpio_s2_q   <= gpio_s1_q;
            gpio_s3_q   <= gpio_s2_q;
            vga_s1_q    <= vga_frame_sync;
            vga_s2_q    <= vga_s1_q;
            vga_s3_q    <= vga_s2_q;
            deb_q       <= deb_d;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            vga_q       <= vga_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            rdata_q     <= rdata_d;
            io_sel_q    <= io_sel_d;
        end
    end

    assign bus.data_out = io_sel_q ? rdata_q : bus.ram_q;
    assign bus.ram_wren = bus.wren & ~io_space;
    assign player_vga   = vga_q;

    always_comb begin
        gpio_out = '0;
        for (int p = 0; p < NP; p++) gpio_out[p] = (timer_q[p] != 16'd0);
    end
endmodule

// File: tb/tb_mmio_hub.sv
// tb/tb_mmio_hub.sv - directed, table-driven bench for mmio_hub
module tb_mmio_hub;
    localparam int NP = 2;
    localparam int CW = 8;

    logic                 clock = 1'b0;
    logic                 reset_btn = 1'b0;
    logic [NP*CW-1:0]     gpio_in = '0;
    logic [NP-1:0]        gpio_out;
    logic                 vga_frame_sync = 1'b0;
    logic [NP*128-1:0]    player_vga;

    int total = 0;
    int bad   = 0;

    mmio_hub_if #(.ADDR_WIDTH(13)) bus ();

    mmio_hub #(
        .NUM_PLAYERS(NP), .CTRL_WIDTH(CW), .ADDR_WIDTH(13),
        .IO_BASE(13'h1F00), .DB_CYCLES(4)
    ) dut (
        .clock(clock), .reset_btn(reset_btn), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out),
        .vga_frame_sync(vga_frame_sync), .player_vga(player_vga)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [12:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ramq;
        logic        exp_rw;
        logic [31:0] exp_do;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        bus.address = a;
        bus.data_in = d;
        bus.wren    = 1'b1;
        @(negedge clock);
        bus.wren    = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [31:0] v);
        bus.address = a;
        bus.wren    = 1'b0;
        @(negedge clock);
        v = bus.data_out;
    endtask

    task automatic frame_pulse(input bit wr_commit, input logic [12:0] a, input logic [31:0] d,
                               output logic [255:0] pv_pre);
        vga_frame_sync = 1'b1;
        @(negedge clock);
        @(negedge clock);
        vga_frame_sync = 1'b0;
        pv_pre = player_vga;
        if (wr_commit) begin
            bus.address = a;
            bus.data_in = d;
            bus.wren    = 1'b1;
        end
        @(negedge clock);
        bus.wren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  v;
        logic [255:0] pv;
        logic [255:0] exp_pv;
        int           n;

        bus.address = '0;
        bus.data_in = '0;
        bus.wren    = 1'b0;
        bus.ram_q   = '0;

        #1;
        check("reset_data_out", 256'(bus.data_out), 256'(0));
        check("reset_gpio_out", 256'(gpio_out), 256'(0));
        check("reset_player_vga", 256'(player_vga), 256'(0));
        check("reset_ram_wren", 256'(bus.ram_wren), 256'(0));
        @(negedge clock);
        @(negedge clock);
        reset_btn = 1'b1;

        vecs[0]  = '{13'h0010, 1'b1, 32'h1234,     32'h0,    1'b1, 32'h0};
        vecs[1]  = '{13'h0010, 1'b0, 32'h0,        32'hCAFE, 1'b0, 32'hCAFE};
        vecs[2]  = '{13'h1F00, 1'b1, 32'hDEADBEEF, 32'h1111, 1'b0, 32'h0};
        vecs[3]  = '{13'h1F00, 1'b0, 32'h0,        32'h2222, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{13'h1F07, 1'b0, 32'h0,        32'h0,    1'b0, 32'h1};
        vecs[5]  = '{13'h1F0F, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0};
        vecs[6]  = '{13'h1F10, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0};
        vecs[7]  = '{13'h1F11, 1'b0, 32'h0,        32'hFFFF, 1'b0, 32'h0};
        vecs[8]  = '{13'h1F04, 1'b1, 32'hFF,       32'h0,    1'b0, 32'h0};
        vecs[9]  = '{13'h1F04, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0};
        vecs[10] = '{13'h1EFF, 1'b0, 32'h0,        32'h77,   1'b0, 32'h77};
        vecs[11] = '{13'h1EFF, 1'b1, 32'h5,        32'h88,   1'b1, 32'h88};
        vecs[12] = '{13'h1F11, 1'b1, 32'hAB,       32'h0,    1'b0, 32'h0};
        vecs[13] = '{13'h1F1F, 1'b0, 32'h0,        32'h1234, 1'b0, 32'h0};

        @(negedge clock);
        for (int i = 0; i < 14; i++) begin
            bus.address = vecs[i].addr;
            bus.wren    = vecs[i].we;
            bus.data_in = vecs[i].wdata;
            bus.ram_q   = vecs[i].ramq;
            #1;
            check($sformatf("vec%0d_ram_wren", i), 256'(bus.ram_wren), 256'(vecs[i].exp_rw));
            @(negedge clock);
            check($sformatf("vec%0d_data_out", i), 256'(bus.data_out), 256'(vecs[i].exp_do));
        end
        bus.wren  = 1'b0;
        bus.ram_q = '0;

        wr(13'h1F08, 32'h11);
        wr(13'h1F09, 32'h22);
        wr(13'h1F0A, 32'h33);
        wr(13'h1F0B, 32'h44);
        check("sprite_pre_commit_vga", 256'(player_vga), 256'(0));
        rd(13'h1F0F, v);
        check("status_p1_pending", 256'(v), 256'(1));
        frame_pulse(1'b0, 13'h0, 32'h0, pv);
        check("vga_before_third_edge", pv, 256'(0));
        exp_pv = {32'h44, 32'h33, 32'h22, 32'h11, 96'h0, 32'hDEADBEEF};
        check("vga_after_commit", 256'(player_vga), exp_pv);
        rd(13'h1F0F, v);
        check("status_p1_cleared", 256'(v), 256'(0));
        rd(13'h1F10, v);
        check("frame_count_1", 256'(v), 256'(1));

        repeat (3) @(negedge clock);
        frame_pulse(1'b1, 13'h1F08, 32'h99, pv);
        check("collide_vga_old_shadow", 256'(player_vga), exp_pv);
        rd(13'h1F0F, v);
        check("collide_status_stays", 256'(v), 256'(1));
        rd(13'h1F08, v);
        check("collide_shadow_written", 256'(v), 256'(32'h99));
        rd(13'h1F10, v);
        check("frame_count_2", 256'(v), 256'(2));

        gpio_in[2] = 1'b1;
        repeat (3) @(negedge clock);
        gpio_in[2] = 1'b0;
        repeat (10) @(negedge clock);
        rd(13'h1F04, v);
        check("glitch_state", 256'(v), 256'(0));
        rd(13'h1F05, v);
        check("glitch_edges", 256'(v), 256'(0));

        gpio_in[2] = 1'b1;
        repeat (5) @(negedge clock);
        rd(13'h1F04, v);
        check("press_not_yet", 256'(v), 256'(0));
        repeat (6) @(negedge clock);
        rd(13'h1F04, v);
        check("press_state", 256'(v), 256'(32'h04));
        rd(13'h1F05, v);
        check("press_edges_first", 256'(v), 256'(32'h04));
        rd(13'h1F05, v);
        check("press_edges_cleared", 256'(v), 256'(0));
        rd(13'h1F0C, v);
        check("p1_state_untouched", 256'(v), 256'(0));

        wr(13'h1F06, 32'd5);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (gpio_out[0]) n++;
            @(negedge clock);
        end
        check("rumble_5_cycles", 256'(n), 256'(5));
        check("rumble_p1_idle", 256'(gpio_out[1]), 256'(0));

        wr(13'h1F06, 32'd5);
        @(negedge clock);
        @(negedge clock);
        wr(13'h1F06, 32'd3);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (gpio_out[0]) n++;
            @(negedge clock);
        end
        check("rumble_reload_3", 256'(n), 256'(3));

        wr(13'h1F06, 32'd9);
        wr(13'h1F06, 32'd0);
        check("rumble_stop", 256'(gpio_out[0]), 256'(0));

        wr(13'h1F06, 32'd100);
        rd(13'h1F06, v);
        check("rumble_readback", 256'(v), 256'(100));
        wr(13'h1F06, 32'd0);

        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt_q;
        rd(13'h1F10, v);
        check("frame_count_preset", 256'(v), 256'(32'hFFFF_FFFF));
        frame_pulse(1'b0, 13'h0, 32'h0, pv);
        rd(13'h1F10, v);
        check("frame_count_wrap", 256'(v), 256'(0));

        wr(13'h1F06, 32'd200);
        gpio_in[3] = 1'b1;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #3;
        reset_btn = 1'b0;
        gpio_in   = '0;
        #1;
        check("midop_gpio_out", 256'(gpio_out), 256'(0));
        check("midop_player_vga", 256'(player_vga), 256'(0));
        check("midop_data_out", 256'(bus.data_out), 256'(0));
        repeat (2) @(negedge clock);
        reset_btn = 1'b1;
        #1;
        check("release_data_out", 256'(bus.data_out), 256'(0));
        @(negedge clock);
        rd(13'h1F04, v);
        check("post_reset_state", 256'(v), 256'(0));
        rd(13'h1F06, v);
        check("post_reset_timer", 256'(v), 256'(0));
        rd(13'h1F10, v);
        check("post_reset_fc", 256'(v), 256'(0));
        repeat (8) @(negedge clock);
        rd(13'h1F04, v);
        check("post_reset_no_debounce", 256'(v), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
